alu_exec_seq: RTL and testbench
===============================

// Module: alu_exec_seq
// PURPOSE
// - Execute sequencer directly upstream of the 8-bit ALU: accepts one instruction per handshake,
//   reads two operands from a local 4x8 register file, drives IRa/IRb/OPALU of the ALU,
//   captures OALUD/OFgz/OFgn, writes the result back to rd and holds the Z/N flags.
// - The ALU is external and purely combinational; this block is the only driver of its inputs.
// PARAMETERS
// - DW    8  datapath width (ALU operand/result width)
// - NREG  4  register count; AW = $clog2(NREG) = 2 (instruction format fixes AW = 2)
// PORTS
// - ICLK     in   1   clock, all state on rising edge
// - IRSTN    in   1   reset, asynchronous, active-low
// - IINSTR   in   8   instruction: [7:5] op, [4] reserved (ignored), [3:2] rd, [1:0] rs
// - IVALID   in   1   IINSTR valid
// - OREADY   out  1   sequencer can accept; transfer when IVALID & OREADY at a clock edge
// - IWE      in   1   external register-file write (preload)
// - IWADDR   in   2   external write address
// - IWDATA   in   DW  external write data
// - ORA      out  DW  to ALU IRa (registered)
// - ORB      out  DW  to ALU IRb (registered)
// - OOPALU   out  4   to ALU OPALU (registered)
// - IALUD    in   DW  from ALU OALUD
// - IFGZ     in   1   from ALU OFgz
// - IFGN     in   1   from ALU OFgn
// - OZ       out  1   zero flag register
// - ON       out  1   negative flag register
// - OHALT    out  1   sequencer halted
// - IDBGSEL  in   2   debug read select
// - ODBGD    out  DW  combinational read of R[IDBGSEL]
// BEHAVIOUR
// - Reset (async, IRSTN=0): state IDLE; R0..R3, ORA, ORB, OOPALU, OZ, ON, result reg = 0; OHALT=0.
// - OREADY = (state == IDLE); it is 1 in the first cycle after reset release.
// - Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 NAND, 100 SHL, 101 SHR, 110 MOV rd<-rs, 111 HALT.
//   OPALU = {1'b0, op} for op 1..5; OPALU = 0 for all other ops.
// - FSM: IDLE -> DEC on accept; instruction latched at the accept edge.
//   DEC: ORA<=R[rd], ORB<=R[rs], OOPALU<=alu code.
//     NOP -> IDLE.
//     HALT -> HALTED.
//     MOV -> WB.
//     op 1..5 -> EXE.
//   EXE: ALU settles; result reg<=IALUD; zf<=IFGZ; nf<=IFGN -> WB.
//   WB: R[rd]<=result (MOV: ORB); OZ/ON<=zf/nf (ALU ops only) -> IDLE.
//     OOPALU returns to 0 at the WB edge.
//   HALTED: OHALT=1, OREADY=0; exits only on reset.
// - Latency, accept edge = N:
//   - ALU op: write visible at edge N+3; OREADY=1 again after edge N+3.
//   - MOV: write at edge N+2.
//   - NOP: OREADY back after edge N+1.
// - Flags: updated only by ALU ops. MOV, NOP and HALT leave OZ/ON unchanged.
//   OZ/ON mirror the ALU's own flag semantics, taken verbatim; no recomputation here.
// - Width: all arithmetic is in the ALU, modulo 2^DW, no carry out.
// - External write: IWE is honoured only in IDLE and ignored in all other states.
//   - IWE with an accept in the same IDLE cycle: the write lands at that edge; DEC reads the new value.
//   - rd == rs is legal, e.g. ADD R1,R1 doubles R1.
// - IVALID while OREADY=0: no effect; upstream must hold IINSTR until accepted.
// - Reset mid-operation: instruction abandoned, no write-back, all state returns to reset values.
// - ODBGD is combinational from the register file; it reflects a write in the cycle after the write edge.
// STRUCTURE
// - Shared package alu_pkg:
//   - opcode localparams OP_NOP..OP_HALT
//   - ALU code constants ALU_ADD=1..ALU_SHR=5
//   - state encoding S_IDLE, S_DEC, S_EXE, S_WB, S_HALT (3-bit)
// - Sub-module regfile_4x8:
//   - async-reset flops
//   - one write port with priority WB over external
//   - two sync-sampled read ports plus one combinational debug read port
// - Remaining logic in this module: FSM, instruction latch, result/flag capture.
// TESTING (bench instantiates the ALU behind this block)
// - Reset: IRSTN=0 mid-EXE -> ORA/ORB/OOPALU/OZ/ON=0, OREADY=1, no register changed.
// - Preload R0=0x7F, R1=0x01; ADD R0,R1 (0x21) -> R0=0x80 at accept+3 edges, ON=1, OZ=0.
// - Preload R2=0x05, R3=0x05; SUB R2,R3 (0x4B) -> R2=0x00, OZ=1, ON=0.
//   Then MOV R1,R2 (0xC6) -> R1=0x00, flags unchanged.
// - R3=0x81: SHL R3 (0x8C) -> R3=0x02, OZ=1 (bit7 shifted out), ON=0.
//   Then SHR R3 -> R3=0x01, OZ=0.
// - Back-to-back: IVALID held high with 4 instructions -> exactly 4 accepts, each at OREADY=1;
//   IWE during EXE is ignored.
// - HALT (0xE0) -> OHALT=1, OREADY stays 0 for 20 cycles with IVALID=1; reset clears OHALT.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute sequencer: opcodes, ALU codes, FSM encoding.
package alu_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_MOV  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_NAND = 4'd3;
  localparam logic [3:0] ALU_SHL  = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_EXE  = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  // Only the five arithmetic/logic opcodes drive a non-zero ALU code.
  function automatic logic [3:0] alu_code(input logic [2:0] op);
    case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_NAND: alu_code = ALU_NAND;
      OP_SHL:  alu_code = ALU_SHL;
      OP_SHR:  alu_code = ALU_SHR;
      default: alu_code = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_seq_regfile.sv
// 4x8 register file: one write port (write-back beats external preload),
// two read ports sampled by the decode-stage registers, one combinational debug port.
module regfile_4x8
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem_r [NREG];

  // Register storage with write-back taking priority over the preload port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_r[i] <= '0;
    end else if (wb_we) begin
      mem_r[wb_addr] <= wb_data;
    end else if (ext_we) begin
      mem_r[ext_addr] <= ext_data;
    end
  end

  assign rd_data_a = mem_r[rd_addr_a];
  assign rd_data_b = mem_r[rd_addr_b];
  assign dbg_data  = mem_r[dbg_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Execute sequencer in front of an external combinational 8-bit ALU:
// accept, decode/operand fetch, execute, write back, with sticky Z/N flags.
module alu_exec_seq
  import alu_pkg::*;
(
  input  logic          ICLK,
  input  logic          IRSTN,
  input  logic [7:0]    IINSTR,
  input  logic          IVALID,
  output logic          OREADY,
  input  logic          IWE,
  input  logic [AW-1:0] IWADDR,
  input  logic [DW-1:0] IWDATA,
  output logic [DW-1:0] ORA,
  output logic [DW-1:0] ORB,
  output logic [3:0]    OOPALU,
  input  logic [DW-1:0] IALUD,
  input  logic          IFGZ,
  input  logic          IFGN,
  output logic          OZ,
  output logic          ON,
  output logic          OHALT,
  input  logic [AW-1:0] IDBGSEL,
  output logic [DW-1:0] ODBGD
);

  state_t        state_r, state_s;
  logic [7:0]    instr_r;
  logic [DW-1:0] ora_r, orb_r, result_r;
  logic [3:0]    oopalu_r;
  logic          zf_r, nf_r, oz_r, on_r;
  logic [2:0]    op_s;
  logic [AW-1:0] rd_s, rs_s;
  logic [DW-1:0] rdata_a_s, rdata_b_s, wb_data_s;
  logic          accept_s, wb_we_s, ext_we_s;
  logic          unused_ok_s;

  assign op_s        = instr_r[7:5];
  assign rd_s        = instr_r[3:2];
  assign rs_s        = instr_r[1:0];
  assign unused_ok_s = instr_r[4];

  assign OREADY    = (state_r == S_IDLE);
  assign OHALT     = (state_r == S_HALT);
  assign accept_s  = IVALID && OREADY;
  assign ext_we_s  = IWE && (state_r == S_IDLE);
  assign wb_we_s   = (state_r == S_WB);
  assign wb_data_s = (op_s == OP_MOV) ? orb_r : result_r;

  regfile_4x8 u_regfile (
    .clk       (ICLK),
    .rst_n     (IRSTN),
    .wb_we     (wb_we_s),
    .wb_addr   (rd_s),
    .wb_data   (wb_data_s),
    .ext_we    (ext_we_s),
    .ext_addr  (IWADDR),
    .ext_data  (IWDATA),
    .rd_addr_a (rd_s),
    .rd_data_a (rdata_a_s),
    .rd_addr_b (rs_s),
    .rd_data_b (rdata_b_s),
    .dbg_addr  (IDBGSEL),
    .dbg_data  (ODBGD)
  );

  // Sequencer next-state decode; HALT is left only through reset.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_s = S_DEC;
        else          state_s = S_IDLE;
      end
      S_DEC: begin
        case (op_s)
          OP_NOP:  state_s = S_IDLE;
          OP_HALT: state_s = S_HALT;
          OP_MOV:  state_s = S_WB;
          default: state_s = S_EXE;
        endcase
      end
      S_EXE:   state_s = S_WB;
      S_WB:    state_s = S_IDLE;
      S_HALT:  state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ICLK or negedge IRSTN) begin
    if (!IRSTN) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Instruction latch, ALU input drive, result/flag capture and flag commit.
  always_ff @(posedge ICLK or negedge IRSTN) begin
    if (!IRSTN) begin
      instr_r  <= 8'h00;
      ora_r    <= '0;
      orb_r    <= '0;
      oopalu_r <= 4'd0;
      result_r <= '0;
      zf_r     <= 1'b0;
      nf_r     <= 1'b0;
      oz_r     <= 1'b0;
      on_r     <= 1'b0;
    end else begin
      if (accept_s) instr_r <= IINSTR;
      case (state_r)
        S_DEC: begin
          ora_r    <= rdata_a_s;
          orb_r    <= rdata_b_s;
          oopalu_r <= alu_code(op_s);
        end
        S_EXE: begin
          result_r <= IALUD;
          zf_r     <= IFGZ;
          nf_r     <= IFGN;
        end
        S_WB: begin
          // MOV reaches WB without touching the captured flags.
          if (op_s != OP_MOV) begin
            oz_r <= zf_r;
            on_r <= nf_r;
          end
          oopalu_r <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign ORA    = ora_r;
  assign ORB    = orb_r;
  assign OOPALU = oopalu_r;
  assign OZ     = oz_r;
  assign ON     = on_r;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq with a behavioural ALU behind it.
module tb_alu_exec_seq;

  logic       ICLK = 1'b0;
  logic       IRSTN;
  logic [7:0] IINSTR;
  logic       IVALID;
  logic       OREADY;
  logic       IWE;
  logic [1:0] IWADDR;
  logic [7:0] IWDATA;
  logic [7:0] ORA, ORB;
  logic [3:0] OOPALU;
  logic [7:0] IALUD;
  logic       IFGZ, IFGN;
  logic       OZ, ON, OHALT;
  logic [1:0] IDBGSEL;
  logic [7:0] ODBGD;

  int checks  = 0;
  int errors  = 0;
  int accepts = 0;

  alu_exec_seq dut (
    .ICLK(ICLK), .IRSTN(IRSTN), .IINSTR(IINSTR), .IVALID(IVALID), .OREADY(OREADY),
    .IWE(IWE), .IWADDR(IWADDR), .IWDATA(IWDATA), .ORA(ORA), .ORB(ORB), .OOPALU(OOPALU),
    .IALUD(IALUD), .IFGZ(IFGZ), .IFGN(IFGN), .OZ(OZ), .ON(ON), .OHALT(OHALT),
    .IDBGSEL(IDBGSEL), .ODBGD(ODBGD)
  );

  always #10 ICLK = ~ICLK;

  // Behavioural ALU: shifts report the shifted-out bit on OFgz, others report zero result.
  always_comb begin
    IALUD = 8'h00;
    IFGZ  = 1'b0;
    case (OOPALU)
      4'd1: IALUD = ORA + ORB;
      4'd2: IALUD = ORA - ORB;
      4'd3: IALUD = ~(ORA & ORB);
      4'd4: IALUD = {ORA[6:0], 1'b0};
      4'd5: IALUD = {1'b0, ORA[7:1]};
      default: IALUD = 8'h00;
    endcase
    if (OOPALU == 4'd4)      IFGZ = ORA[7];
    else if (OOPALU == 4'd5) IFGZ = ORA[0];
    else                     IFGZ = (IALUD == 8'h00);
    IFGN = IALUD[7];
  end

  always @(posedge ICLK) begin
    if (IRSTN && IVALID && OREADY) accepts++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ICLK);
    #1;
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    IDBGSEL = a;
    #1;
    chk(tag, ODBGD, exp);
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    IWE = 1'b1; IWADDR = a; IWDATA = d;
    tick(1);
    IWE = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int b = 0;
    while (!OREADY && b < 50) begin
      tick(1);
      b++;
    end
    chk(tag, {7'd0, OREADY}, 8'h01);
  endtask

  task automatic issue(input logic [7:0] instr);
    wait_ready("ready_before_issue");
    IINSTR = instr; IVALID = 1'b1;
    tick(1);
    IVALID = 1'b0;
  endtask

  logic [7:0] bb [4];
  int acc0, rdy_cnt;

  initial begin
    IRSTN = 1'b0; IINSTR = 8'h00; IVALID = 1'b0; IWE = 1'b0;
    IWADDR = 2'd0; IWDATA = 8'h00; IDBGSEL = 2'd0;
    bb[0] = 8'h21; bb[1] = 8'h64; bb[2] = 8'h00; bb[3] = 8'hC9;
    tick(2);
    IRSTN = 1'b1;
    #1;
    chk("rst_oready", {7'd0, OREADY}, 8'h01);
    chk("rst_ohalt", {7'd0, OHALT}, 8'h00);
    chk("rst_oopalu", {4'd0, OOPALU}, 8'h00);
    chk("rst_ora", ORA, 8'h00);
    chk("rst_flags", {6'd0, OZ, ON}, 8'h00);

    // ADD R0,R1: 0x7F + 0x01
    preload(2'd0, 8'h7F);
    preload(2'd1, 8'h01);
    issue(8'h21);
    tick(1);
    chk("add_opalu", {4'd0, OOPALU}, 8'h01);
    chk("add_ora", ORA, 8'h7F);
    chk("add_orb", ORB, 8'h01);
    tick(1);
    reg_chk("add_r0_not_yet", 2'd0, 8'h7F);
    tick(1);
    reg_chk("add_r0", 2'd0, 8'h80);
    chk("add_flags", {6'd0, OZ, ON}, 8'h01);
    chk("add_opalu_cleared", {4'd0, OOPALU}, 8'h00);
    chk("add_ready_again", {7'd0, OREADY}, 8'h01);

    // SUB R2,R3 then MOV R1,R2
    preload(2'd2, 8'h05);
    preload(2'd3, 8'h05);
    issue(8'h4B);
    tick(3);
    reg_chk("sub_r2", 2'd2, 8'h00);
    chk("sub_flags", {6'd0, OZ, ON}, 8'h02);
    issue(8'hC6);
    tick(1);
    reg_chk("mov_r1_not_yet", 2'd1, 8'h01);
    chk("mov_opalu", {4'd0, OOPALU}, 8'h00);
    tick(1);
    reg_chk("mov_r1", 2'd1, 8'h00);
    chk("mov_flags", {6'd0, OZ, ON}, 8'h02);
    chk("mov_ready", {7'd0, OREADY}, 8'h01);

    // SHL R3 then SHR R3
    preload(2'd3, 8'h81);
    issue(8'h8C);
    tick(3);
    reg_chk("shl_r3", 2'd3, 8'h02);
    chk("shl_flags", {6'd0, OZ, ON}, 8'h02);
    issue(8'hAC);
    tick(3);
    reg_chk("shr_r3", 2'd3, 8'h01);
    chk("shr_flags", {6'd0, OZ, ON}, 8'h00);

    // NOP returns to ready after one edge
    issue(8'h00);
    chk("nop_busy", {7'd0, OREADY}, 8'h00);
    tick(1);
    chk("nop_ready", {7'd0, OREADY}, 8'h01);

    // Preload + accept in the same cycle, ADD R2,R2; IWE during EXE ignored
    wait_ready("ready_same_cycle");
    IWE = 1'b1; IWADDR = 2'd2; IWDATA = 8'h11;
    IINSTR = 8'h2A; IVALID = 1'b1;
    tick(1);
    IWE = 1'b0; IVALID = 1'b0;
    tick(1);
    chk("same_cycle_ora", ORA, 8'h11);
    IWE = 1'b1; IWADDR = 2'd2; IWDATA = 8'hAA;
    tick(1);
    IWE = 1'b0;
    tick(1);
    reg_chk("rd_eq_rs_r2", 2'd2, 8'h22);

    // Back-to-back with IVALID held high
    preload(2'd0, 8'h03);
    preload(2'd1, 8'h0C);
    acc0 = accepts;
    IVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IINSTR = bb[i];
      wait_ready("b2b_ready_at_accept");
      tick(1);
    end
    IVALID = 1'b0;
    tick(3);
    chk("b2b_accepts", 8'(accepts - acc0), 8'd4);
    reg_chk("b2b_r0", 2'd0, 8'h0F);
    reg_chk("b2b_r1", 2'd1, 8'hF3);
    reg_chk("b2b_r2", 2'd2, 8'hF3);
    chk("b2b_flags", {6'd0, OZ, ON}, 8'h01);

    // Reset in the middle of EXE
    issue(8'h21);
    tick(1);
    chk("pre_rst_opalu", {4'd0, OOPALU}, 8'h01);
    IRSTN = 1'b0;
    #1;
    chk("mid_rst_ora", ORA, 8'h00);
    chk("mid_rst_orb", ORB, 8'h00);
    chk("mid_rst_opalu", {4'd0, OOPALU}, 8'h00);
    chk("mid_rst_flags", {6'd0, OZ, ON}, 8'h00);
    chk("mid_rst_ready", {7'd0, OREADY}, 8'h01);
    tick(2);
    IRSTN = 1'b1;
    tick(3);
    reg_chk("mid_rst_r0", 2'd0, 8'h00);
    reg_chk("mid_rst_r1", 2'd1, 8'h00);
    reg_chk("mid_rst_r2", 2'd2, 8'h00);

    // HALT holds off further accepts until reset
    issue(8'hE0);
    tick(1);
    chk("halt_ohalt", {7'd0, OHALT}, 8'h01);
    acc0 = accepts;
    rdy_cnt = 0;
    IINSTR = 8'h21; IVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (OREADY) rdy_cnt++;
    end
    chk("halt_ready_cycles", 8'(rdy_cnt), 8'd0);
    chk("halt_no_accepts", 8'(accepts - acc0), 8'd0);
    chk("halt_still", {7'd0, OHALT}, 8'h01);
    IVALID = 1'b0;
    IRSTN = 1'b0;
    tick(1);
    IRSTN = 1'b1;
    #1;
    chk("halt_cleared", {7'd0, OHALT}, 8'h00);
    chk("halt_rst_ready", {7'd0, OREADY}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
